slider_move_tracker: RTL and testbench

//   Observer for the 3x3 sliding-tile puzzle board. Watches successive board snapshots,

---
 rtl/slider_move_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_slider_move_tracker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slider_move_tracker.sv
// Decodes successive 3x3 sliding-puzzle snapshots into blank-move directions,
// flags illegal steps, and keeps a circular LIFO of moves for undo requests.
module slider_move_tracker #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     board_vld,
    input  logic [35:0]              board,
    input  logic                     resync,
    output logic                     move_vld,
    output logic [1:0]               move_dir,
    output logic                     illegal,
    input  logic                     undo_req,
    output logic                     undo_ack,
    output logic [1:0]               undo_dir,
    output logic                     undo_err,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [CNT_W-1:0]         move_cnt,
    output logic                     solved
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);
    localparam logic [35:0] SOLVED_BOARD = 36'h876543210;

    typedef enum logic [1:0] {NOREF, TRACK, ERROR} state_e;

    state_e            state_q, state_d;
    logic [35:0]       ref_q, ref_d;
    logic [1:0]        mem_q [DEPTH];
    logic [1:0]        mem_d [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW:0]       depth_q, depth_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        pend_dir_q, pend_dir_d;
    logic              move_vld_q, move_vld_d, illegal_q, illegal_d;
    logic [1:0]        move_dir_q, move_dir_d, undo_dir_q, undo_dir_d;
    logic              undo_ack_q, undo_ack_d, undo_err_q, undo_err_d;
    logic              solved_q, solved_d;

    function automatic logic [1:0] row_of(input logic [3:0] i);
        return (i >= 4'd6) ? 2'd2 : (i >= 4'd3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] i);
        return 2'(i - 4'(row_of(i)) * 4'd3);
    endfunction

    // Snapshot decode against the reference board
    logic [3:0] n_blank, n_diff, nb_idx, ob_idx;
    logic [1:0] ob_r, ob_c, nb_r, nb_c, dir;
    logic       same_row, same_col, adj, tile_ok, legal;

    always_comb begin
        n_blank = 4'd0;
        n_diff  = 4'd0;
        nb_idx  = 4'd0;
        ob_idx  = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (board[4*i +: 4] == 4'd0) begin
                n_blank = n_blank + 4'd1;
                nb_idx  = 4'(i);
            end
            if (ref_q[4*i +: 4] == 4'd0) ob_idx = 4'(i);
            if (board[4*i +: 4] != ref_q[4*i +: 4]) n_diff = n_diff + 4'd1;
        end
        ob_r     = row_of(ob_idx);
        ob_c     = col_of(ob_idx);
        nb_r     = row_of(nb_idx);
        nb_c     = col_of(nb_idx);
        same_row = (ob_r == nb_r);
        same_col = (ob_c == nb_c);
        adj      = (same_row && (nb_c == ob_c + 2'd1 || ob_c == nb_c + 2'd1)) ||
                   (same_col && (nb_r == ob_r + 2'd1 || ob_r == nb_r + 2'd1));
        tile_ok  = (board[{ob_idx, 2'b00} +: 4] == ref_q[{nb_idx, 2'b00} +: 4]);
        // With exactly two differing cells, these checks pin them to the two blank cells
        legal    = (n_blank == 4'd1) && (n_diff == 4'd2) && adj && tile_ok;
        dir      = same_row ? ((nb_c > ob_c) ? 2'd1 : 2'd0)
                            : ((nb_r > ob_r) ? 2'd3 : 2'd2);
    end

    logic push;

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        mem_d      = mem_q;
        ptr_d      = ptr_q;
        depth_d    = depth_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        move_vld_d = 1'b0;
        move_dir_d = 2'd0;
        illegal_d  = illegal_q;
        undo_ack_d = 1'b0;
        undo_dir_d = 2'd0;
        undo_err_d = 1'b0;
        push       = 1'b0;
        if (resync) begin
            state_d   = NOREF;
            ptr_d     = '0;
            depth_d   = '0;
            cnt_d     = '0;
            illegal_d = 1'b0;
            pend_d    = 1'b0;
        end else begin
            if (board_vld) begin
                case (state_q)
                    NOREF: begin
                        ref_d   = board;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (n_diff != 4'd0) begin
                            if (legal) begin
                                move_vld_d = 1'b1;
                                move_dir_d = dir;
                                ref_d      = board;
                                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                                // The move that carries out an undo is not logged again
                                push   = !(pend_q && dir == pend_dir_q);
                                pend_d = 1'b0;
                            end else begin
                                illegal_d = 1'b1;
                                state_d   = ERROR;
                                pend_d    = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (push) begin
                mem_d[ptr_q] = dir;
                ptr_d        = ptr_q + 1'b1;
                if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
            end
            // The ack cycle itself is skipped so a still-high req is not served twice
            if (undo_req && !push && !undo_ack_q) begin
                undo_ack_d = 1'b1;
                if (depth_q != '0 && state_q != ERROR) begin
                    undo_dir_d = mem_q[ptr_q - 1'b1] ^ 2'd1;
                    ptr_d      = ptr_q - 1'b1;
                    depth_d    = depth_q - 1'b1;
                    pend_d     = 1'b1;
                    pend_dir_d = undo_dir_d;
                end else begin
                    undo_err_d = 1'b1;
                end
            end
        end
        solved_d = (state_d == TRACK) && (ref_d == SOLVED_BOARD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NOREF;
            ref_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
            ptr_q      <= '0;
            depth_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_dir_q <= 2'd0;
            move_vld_q <= 1'b0;
            move_dir_q <= 2'd0;
            illegal_q  <= 1'b0;
            undo_ack_q <= 1'b0;
            undo_dir_q <= 2'd0;
            undo_err_q <= 1'b0;
            solved_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            mem_q      <= mem_d;
            ptr_q      <= ptr_d;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            move_vld_q <= move_vld_d;
            move_dir_q <= move_dir_d;
            illegal_q  <= illegal_d;
            undo_ack_q <= undo_ack_d;
            undo_dir_q <= undo_dir_d;
            undo_err_q <= undo_err_d;
            solved_q   <= solved_d;
        end
    end

    assign move_vld = move_vld_q;
    assign move_dir = move_dir_q;
    assign illegal  = illegal_q;
    assign undo_ack = undo_ack_q;
    assign undo_dir = undo_dir_q;
    assign undo_err = undo_err_q;
    assign depth    = depth_q;
    assign move_cnt = cnt_q;
    assign solved   = solved_q;
endmodule

// File: tb/tb_slider_move_tracker.sv
// Bench for slider_move_tracker: directed scenarios plus random play, all checked
// against a tile-array / queue model of the puzzle observer.
module tb_slider_move_tracker;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        board_vld = 1'b0;
    logic [35:0] board = '0;
    logic        resync = 1'b0;
    logic        undo_req = 1'b0;
    logic        move_vld, illegal, undo_ack, undo_err, solved;
    logic [1:0]  move_dir, undo_dir;
    logic [$clog2(DEPTH):0] depth;
    logic [CNT_W-1:0] move_cnt;

    slider_move_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .board_vld(board_vld), .board(board), .resync(resync),
        .move_vld(move_vld), .move_dir(move_dir), .illegal(illegal),
        .undo_req(undo_req), .undo_ack(undo_ack), .undo_dir(undo_dir), .undo_err(undo_err),
        .depth(depth), .move_cnt(move_cnt), .solved(solved)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: tile arrays (index = 3*row + col, 0 = blank) and a move queue
    int cur [9];
    int mref [9];
    int stk [$];
    int ms;              // 0 no reference, 1 tracking, 2 error
    int cnt;
    bit pend;
    int pend_dir;
    bit e_mv, e_ill, e_ack, e_uerr, e_solved;
    int e_dir, e_udir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pack_cur();
        logic [35:0] p;
        for (int i = 0; i < 9; i++) p[4*i +: 4] = 4'(cur[i]);
        return p;
    endfunction

    function automatic void model_reset();
        ms = 0; stk.delete(); cnt = 0; pend = 0; pend_dir = 0;
        e_mv = 0; e_dir = 0; e_ill = 0; e_ack = 0; e_udir = 0; e_uerr = 0; e_solved = 0;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_step(input bit bv, input bit rs, input bit ur);
        int nb_cnt, nb, ob, ndiff, prev_state, d;
        bit legal, pushed, ack_prev, is_solved;
        ack_prev = e_ack;
        e_mv = 0; e_dir = 0; e_ack = 0; e_udir = 0; e_uerr = 0;
        if (rs) begin
            ms = 0; stk.delete(); cnt = 0; e_ill = 0; pend = 0;
        end else begin
            prev_state = ms;
            pushed = 0;
            if (bv && ms == 0) begin
                mref = cur;
                ms = 1;
            end else if (bv && ms == 1) begin
                nb_cnt = 0; nb = 0; ob = 0; ndiff = 0;
                for (int i = 0; i < 9; i++) begin
                    if (cur[i] == 0) begin nb_cnt++; nb = i; end
                    if (mref[i] == 0) ob = i;
                    if (cur[i] != mref[i]) ndiff++;
                end
                if (ndiff != 0) begin
                    legal = (nb_cnt == 1) &&
                            (iabs(nb / 3 - ob / 3) + iabs(nb % 3 - ob % 3) == 1) &&
                            (cur[ob] == mref[nb]);
                    for (int i = 0; i < 9; i++)
                        if (i != ob && i != nb && cur[i] != mref[i]) legal = 0;
                    if (legal) begin
                        d = (nb == ob - 1) ? 0 : (nb == ob + 1) ? 1 : (nb == ob - 3) ? 2 : 3;
                        e_mv = 1; e_dir = d;
                        mref = cur;
                        if (cnt < (1 << CNT_W) - 1) cnt++;
                        if (!(pend && d == pend_dir)) begin
                            if (stk.size() == DEPTH) void'(stk.pop_front());
                            stk.push_back(d);
                            pushed = 1;
                        end
                        pend = 0;
                    end else begin
                        ms = 2; e_ill = 1; pend = 0;
                    end
                end
            end
            if (ur && !pushed && !ack_prev) begin
                e_ack = 1;
                if (stk.size() > 0 && prev_state != 2) begin
                    e_udir = stk.pop_back() ^ 1;
                    pend = 1; pend_dir = e_udir;
                end else begin
                    e_uerr = 1;
                end
            end
        end
        is_solved = (ms == 1);
        for (int i = 0; i < 9; i++) if (mref[i] != i) is_solved = 0;
        e_solved = is_solved;
    endfunction

    task automatic check_all();
        chk("move_vld", 32'(move_vld), 32'(e_mv));
        if (e_mv) chk("move_dir", 32'(move_dir), 32'(e_dir));
        chk("illegal", 32'(illegal), 32'(e_ill));
        chk("undo_ack", 32'(undo_ack), 32'(e_ack));
        if (e_ack) begin
            chk("undo_dir", 32'(undo_dir), 32'(e_udir));
            chk("undo_err", 32'(undo_err), 32'(e_uerr));
        end
        chk("depth", 32'(depth), 32'(stk.size()));
        chk("move_cnt", 32'(move_cnt), 32'(cnt));
        chk("solved", 32'(solved), 32'(e_solved));
    endtask

    // One clock: apply inputs, step the model on the edge, compare just after it
    task automatic drive(input bit bv, input bit rs, input bit ur);
        board_vld = bv; board = pack_cur(); resync = rs; undo_req = ur;
        @(posedge clk);
        #1;
        model_step(bv, rs, ur);
        check_all();
        board_vld = 0; resync = 0; undo_req = 0;
    endtask

    function automatic int blank_pos();
        int p = 0;
        for (int i = 0; i < 9; i++) if (cur[i] == 0) p = i;
        return p;
    endfunction

    function automatic bit can_move(input int d);
        int p = blank_pos();
        case (d)
            0: return (p % 3) > 0;
            1: return (p % 3) < 2;
            2: return (p / 3) > 0;
            default: return (p / 3) < 2;
        endcase
    endfunction

    function automatic void do_move(input int d);
        int p, q;
        p = blank_pos();
        q = (d == 0) ? p - 1 : (d == 1) ? p + 1 : (d == 2) ? p - 3 : p + 3;
        cur[p] = cur[q];
        cur[q] = 0;
    endfunction

    function automatic int rand_dir();
        int d;
        do d = int'($urandom_range(0, 3)); while (!can_move(d));
        return d;
    endfunction

    function automatic void set_solved();
        for (int i = 0; i < 9; i++) cur[i] = i;
    endfunction

    // Holds undo_req until acknowledged; optionally a move lands in the first cycle
    task automatic do_undo(input bit with_move, input int d);
        bit bv;
        int n;
        bv = with_move;
        if (with_move) do_move(d);
        n = 0;
        while (1) begin
            drive(bv, 0, 1);
            bv = 0;
            n++;
            if (e_ack) break;
            if (n >= 4) begin
                errors++;
                $display("FAIL undo_timeout observed=no_ack expected=ack");
                break;
            end
        end
    endtask

    task automatic restart();
        drive(0, 1, 0);
        drive(1, 0, 0);
    endtask

    initial begin
        int a, p, i1, i2;
        set_solved();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: load solved board, then blank slides right
        drive(1, 0, 0);
        chk("t1_solved_on_load", 32'(solved), 32'd1);
        do_move(1);
        drive(1, 0, 0);
        chk("t1_move_vld", 32'(move_vld), 32'd1);
        chk("t1_move_dir", 32'(move_dir), 32'd1);
        chk("t1_depth", 32'(depth), 32'd1);
        chk("t1_solved_clear", 32'(solved), 32'd0);

        // T2: blank slides left with undo_req held in the same cycle
        do_undo(1, 0);
        chk("t2_undo_dir", 32'(undo_dir), 32'd1);
        chk("t2_depth", 32'(depth), 32'd1);

        // T3: executing the undo is not pushed again
        do_move(1);
        drive(1, 0, 0);
        chk("t3_depth", 32'(depth), 32'd1);
        chk("t3_cnt", 32'(move_cnt), 32'd3);

        // T4: swap two tiles without moving the blank
        p = blank_pos();
        i1 = (p + 1) % 9; i2 = (p + 2) % 9;
        a = cur[i1]; cur[i1] = cur[i2]; cur[i2] = a;
        drive(1, 0, 0);
        chk("t4_illegal", 32'(illegal), 32'd1);
        do_undo(0, 0);
        chk("t4_undo_err", 32'(undo_err), 32'd1);
        restart();
        chk("t4_illegal_clr", 32'(illegal), 32'd0);
        chk("t4_depth", 32'(depth), 32'd0);

        // T5: overfill the stack, then drain it
        set_solved();
        restart();
        for (int k = 0; k < DEPTH + 3; k++) begin
            do_move((k % 2 == 0) ? 1 : 0);
            drive(1, 0, 0);
        end
        chk("t5_depth_full", 32'(depth), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            do_undo(0, 0);
            chk("t5_undo_ok", 32'(undo_err), 32'd0);
        end
        do_undo(0, 0);
        chk("t5_undo_empty", 32'(undo_err), 32'd1);

        // T6: collision again, then reset while an undo ack is visible
        do_undo(1, rand_dir());
        do_move(rand_dir());
        drive(1, 0, 0);
        drive(0, 0, 1);
        chk("t6_ack_before_rst", 32'(undo_ack), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 32'({move_vld, move_dir, illegal, undo_ack, undo_dir,
                                    undo_err, solved}), 32'd0);
        chk("t6_rst_depth", 32'(depth), 32'd0);
        chk("t6_rst_cnt", 32'(move_cnt), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;

        // Random play
        set_solved();
        drive(1, 0, 0);
        for (int k = 0; k < 600; k++) begin
            if (ms == 2) begin
                drive(($urandom_range(0, 1) == 1), 0, 0);
                restart();
                continue;
            end
            a = int'($urandom_range(0, 19));
            if (a < 11) begin
                do_move(rand_dir());
                drive(1, 0, 0);
            end else if (a < 12) begin
                drive(1, 0, 0);
            end else if (a < 13) begin
                drive(0, 0, 0);
            end else if (a < 17) begin
                do_undo(0, 0);
            end else if (a < 19) begin
                do_undo(1, rand_dir());
            end else begin
                p = blank_pos();
                i1 = (p + 1) % 9; i2 = (p + 4) % 9;
                a = cur[i1]; cur[i1] = cur[i2]; cur[i2] = a;
                drive(1, 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
